irq_ack_decoder: RTL and testbench
==================================

Name: irq_ack_decoder

Overview:
- Return path for the interrupt priority encoder: converts an accepted 3-bit cause index back into a one-hot acknowledge pulse on the requesting device line.
- Waits for the device to drop its request, then frees itself for the next index.
- Keeps a per-line in-service mask, set at acknowledge and cleared by CPU end-of-interrupt (EOI).
- Sits between the coprocessor-0 interrupt logic (index side) and the external device request lines.

Parameters:
- LINES, 8, number of interrupt lines; one-hot output width.
- IDX_W, 3, index width; LINES = 2**IDX_W.
- ACK_CYCLES, 2, acknowledge pulse length in cycles; legal range 1..15.
- TIMEOUT, 64, WAIT_DROP cycle limit; used only with ACK_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- req_valid  in  1  cause index offered.
- req_idx  in  IDX_W  cause index from the priority encoder.
- req_ready  out  1  index accepted when req_valid & req_ready at a clk edge.
- irq_lines  in  LINES  raw device request levels, already synchronised.
- ack  out  LINES  one-hot acknowledge to devices.
- eoi  in  1  single-cycle end-of-interrupt strobe.
- eoi_idx  in  IDX_W  line whose in-service bit is cleared by eoi.
- in_service  out  LINES  in-service mask.
- spurious  out  1  one-cycle pulse when an accepted index is dropped.
- timeout_err  out  1  sticky error flag; present only with ACK_TIMEOUT_EN.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, ack=0, in_service=0, spurious=0, timeout_err=0, counters=0, held index=0. req_ready goes low while reset is asserted. Reset mid-pulse removes ack immediately, with no settle cycle.
- req_ready = 1 only in IDLE; it is a combinational decode of state.
- FSM states: IDLE, ACK, WAIT_DROP.
- IDLE, accepted index i:
  - If in_service[i]=1 or irq_lines[i]=0: the index is dropped, spurious=1 for the next cycle, state stays IDLE.
  - Otherwise: hold i, set in_service[i], go to ACK, clear the pulse counter.
- ACK: ack = one-hot(i), registered, so ack is high starting the cycle after acceptance. It stays high exactly ACK_CYCLES cycles, then the FSM goes to WAIT_DROP with ack=0.
- WAIT_DROP: when irq_lines[i]=0 on a clk edge, go to IDLE. Minimum accept-to-accept spacing is ACK_CYCLES+2 cycles.
- ack is always zero or exactly one bit; never multi-hot.
- EOI:
  - eoi clears in_service[eoi_idx] in any state.
  - EOI to a bit that is not set has no effect.
  - If eoi and a new set of the same bit land in the same cycle, the clear is applied first and the set second, so the bit ends at 1.
- Index width: req_idx is always in range because LINES = 2**IDX_W; there is no out-of-range handling.
- Pulse counter width: 4 bits.

Optional Feature:
- Macro: ACK_TIMEOUT_EN.
- With the macro defined:
  - A WAIT_DROP counter starts at 0 on entry and increments each cycle.
  - If the counter reaches TIMEOUT-1 while irq_lines[i] is still 1: go to IDLE, set timeout_err (sticky until reset), clear in_service[i].
  - The timeout_err port exists.
- Without the macro: no counter, no timeout_err port, WAIT_DROP waits indefinitely.

Test Plan:
- Reset: hold reset=0 with req_valid=1, irq_lines=8'hFF -> ack=0, in_service=0, req_ready=0. Release reset -> req_ready=1 on the first cycle.
- Basic ack: irq_lines=8'h20, req_idx=5 accepted -> ack=8'h20 for exactly 2 cycles starting the next cycle, in_service=8'h20. Drop irq_lines[5] -> IDLE; req_ready returns high 4 cycles after acceptance.
- Spurious: req_idx=3 with irq_lines[3]=0 -> spurious pulses 1 cycle, ack stays 0, in_service unchanged. Repeat with in_service[3]=1 and irq_lines[3]=1 -> same response.
- EOI collision: in_service=8'h01, then eoi with eoi_idx=0 in the same cycle as accepting index 0 (irq_lines[0]=1) -> in_service[0]=1 and ack=8'h01.
- Async reset mid-ACK: reset=0 one cycle into the ack pulse for index 7 -> ack=0 and in_service=0 before the next clk edge; FSM is in IDLE after release.
- Timeout (ACK_TIMEOUT_EN, TIMEOUT=64): irq_lines[2] held high after the ack for index 2 -> IDLE after 64 WAIT_DROP cycles, timeout_err=1 and stays 1, in_service[2]=0.

Source files
------------

// File: rtl/irq_ack_decoder_if.sv
// rtl/irq_ack_decoder_if.sv - cause-index handshake between the priority encoder and the ack decoder
interface irq_ack_decoder_if #(
  parameter int IDX_W = 3
);
  logic             req_valid;
  logic [IDX_W-1:0] req_idx;
  logic             req_ready;

  // Priority encoder side: offers an index, sees acceptance.
  modport master (output req_valid, output req_idx, input req_ready);
  // Decoder side: consumes an index, signals readiness.
  modport slave  (input req_valid, input req_idx, output req_ready);
endinterface

// File: rtl/irq_ack_decoder.sv
// rtl/irq_ack_decoder.sv - index-to-one-hot interrupt acknowledge with in-service tracking; optional feature macro ACK_TIMEOUT_EN
module irq_ack_decoder #(
  parameter int LINES      = 8,
  parameter int IDX_W      = 3,
  parameter int ACK_CYCLES = 2,
  parameter int TIMEOUT    = 64
) (
  input  logic             clk,
  input  logic             reset,
  irq_ack_decoder_if.slave req,
  input  logic [LINES-1:0] irq_lines,
  output logic [LINES-1:0] ack,
  input  logic             eoi,
  input  logic [IDX_W-1:0] eoi_idx,
  output logic [LINES-1:0] in_service,
  output logic             spurious
`ifdef ACK_TIMEOUT_EN
  ,
  output logic             timeout_err
`endif
);

  // Reject parameter sets the datapath cannot represent.
  if (LINES != (1 << IDX_W) || ACK_CYCLES < 1 || ACK_CYCLES > 15 || TIMEOUT < 1) begin : g_bad_params
    $error("irq_ack_decoder: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ACK       = 2'd1,
    WAIT_DROP = 2'd2
  } state_t;

  state_t           state_q;
  logic [3:0]       cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [LINES-1:0] ack_q;
  logic [LINES-1:0] in_service_q;
  logic [LINES-1:0] in_service_d;
  logic             spurious_q;

  logic             accept;
  logic             take;
  logic             drop;
  logic             timeout_fire;
  logic [LINES-1:0] eoi_mask;
  logic [LINES-1:0] in_service_eoi;

  // While reset is held the state already reads IDLE, so ready is also gated by reset.
  assign req.req_ready = reset && (state_q == IDLE);

  assign accept         = req.req_valid && req.req_ready;
  assign eoi_mask       = eoi ? (LINES'(1) << eoi_idx) : '0;
  // EOI clears before the in-service test, so a same-cycle EOI lets the line be re-acked.
  assign in_service_eoi = in_service_q & ~eoi_mask;
  assign take           = accept && !in_service_eoi[req.req_idx] && irq_lines[req.req_idx];
  assign drop           = accept && !take;

`ifdef ACK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] wd_cnt_q;
  logic            timeout_err_q;

  assign timeout_fire = (state_q == WAIT_DROP) && irq_lines[idx_q] &&
                        (wd_cnt_q == TO_W'(TIMEOUT - 1));
  assign timeout_err  = timeout_err_q;

  // WAIT_DROP watchdog: restarts on every entry, sticky error on expiry.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      if (state_q == WAIT_DROP) begin
        wd_cnt_q <= wd_cnt_q + TO_W'(1);
      end else begin
        wd_cnt_q <= '0;
      end
      if (timeout_fire) begin
        timeout_err_q <= 1'b1;
      end
    end
  end
`else
  assign timeout_fire = 1'b0;
`endif

  // In-service update order: EOI clear, timeout clear, then acknowledge set.
  always_comb begin
    in_service_d = in_service_eoi;
    if (timeout_fire) begin
      in_service_d[idx_q] = 1'b0;
    end
    if (take) begin
      in_service_d[req.req_idx] = 1'b1;
    end
  end

  // Acknowledge FSM with registered ack/spurious/in-service outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      idx_q        <= '0;
      ack_q        <= '0;
      in_service_q <= '0;
      spurious_q   <= 1'b0;
    end else begin
      in_service_q <= in_service_d;
      spurious_q   <= drop;
      case (state_q)
        IDLE: begin
          if (take) begin
            idx_q   <= req.req_idx;
            ack_q   <= LINES'(1) << req.req_idx;
            cnt_q   <= 4'd0;
            state_q <= ACK;
          end
        end
        ACK: begin
          if (cnt_q == 4'(ACK_CYCLES - 1)) begin
            ack_q   <= '0;
            state_q <= WAIT_DROP;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        WAIT_DROP: begin
          if (!irq_lines[idx_q] || timeout_fire) begin
            state_q <= IDLE;
          end
        end
        default: begin
          ack_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack        = ack_q;
  assign in_service = in_service_q;
  assign spurious   = spurious_q;

endmodule

// File: tb/tb_irq_ack_decoder.sv
// tb/tb_irq_ack_decoder.sv - directed-vector bench for irq_ack_decoder
module tb_irq_ack_decoder;

  logic       clk;
  logic       reset;
  logic [7:0] irq_lines;
  logic [7:0] ack;
  logic       eoi;
  logic [2:0] eoi_idx;
  logic [7:0] in_service;
  logic       spurious;
`ifdef ACK_TIMEOUT_EN
  logic       timeout_err;
`endif

  int n_vec;
  int n_err;

  irq_ack_decoder_if #(.IDX_W(3)) req_if ();

  irq_ack_decoder #(
    .LINES(8), .IDX_W(3), .ACK_CYCLES(2), .TIMEOUT(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req_if.slave),
    .irq_lines  (irq_lines),
    .ack        (ack),
    .eoi        (eoi),
    .eoi_idx    (eoi_idx),
    .in_service (in_service),
    .spurious   (spurious)
`ifdef ACK_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept idx on the next edge, run through the pulse, drop the line and return to IDLE.
  task automatic full_cycle(input logic [2:0] idx);
    irq_lines = 8'h01 << idx;
    req_if.req_valid = 1'b1;
    req_if.req_idx   = idx;
    step();
    req_if.req_valid = 1'b0;
    step();
    step();
    irq_lines = 8'h00;
    step();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b0;
    req_if.req_valid = 1'b1;
    req_if.req_idx   = 3'd0;
    irq_lines = 8'hFF;
    eoi = 1'b0;
    eoi_idx = 3'd0;

    // Reset held with traffic present.
    repeat (3) step();
    check_vec("rst_ack", 32'(ack), 32'h00);
    check_vec("rst_insvc", 32'(in_service), 32'h00);
    check_vec("rst_ready", 32'(req_if.req_ready), 32'h0);
    check_vec("rst_spur", 32'(spurious), 32'h0);
    req_if.req_valid = 1'b0;
    irq_lines = 8'h00;
    reset = 1'b1;
    #1;
    check_vec("rel_ready", 32'(req_if.req_ready), 32'h1);

    // Basic acknowledge on line 5.
    step();
    irq_lines = 8'h20;
    req_if.req_valid = 1'b1;
    req_if.req_idx = 3'd5;
    #1;
    check_vec("b_ready0", 32'(req_if.req_ready), 32'h1);
    step();
    req_if.req_valid = 1'b0;
    check_vec("b_ack1", 32'(ack), 32'h20);
    check_vec("b_insvc", 32'(in_service), 32'h20);
    check_vec("b_ready1", 32'(req_if.req_ready), 32'h0);
    step();
    check_vec("b_ack2", 32'(ack), 32'h20);
    step();
    check_vec("b_ack3", 32'(ack), 32'h00);
    check_vec("b_wait_ready", 32'(req_if.req_ready), 32'h0);
    irq_lines = 8'h00;
    step();
    check_vec("b_ready4", 32'(req_if.req_ready), 32'h1);
    check_vec("b_insvc_hold", 32'(in_service), 32'h20);
    eoi = 1'b1; eoi_idx = 3'd5;
    step();
    eoi = 1'b0;
    check_vec("b_eoi", 32'(in_service), 32'h00);

    // Spurious: request line low.
    irq_lines = 8'h00;
    req_if.req_valid = 1'b1; req_if.req_idx = 3'd3;
    step();
    req_if.req_valid = 1'b0;
    check_vec("s1_spur", 32'(spurious), 32'h1);
    check_vec("s1_ack", 32'(ack), 32'h00);
    check_vec("s1_insvc", 32'(in_service), 32'h00);
    check_vec("s1_ready", 32'(req_if.req_ready), 32'h1);
    step();
    check_vec("s1_spur_end", 32'(spurious), 32'h0);

    // Spurious: line already in service.
    full_cycle(3'd3);
    check_vec("s2_pre", 32'(in_service), 32'h08);
    irq_lines = 8'h08;
    req_if.req_valid = 1'b1; req_if.req_idx = 3'd3;
    step();
    req_if.req_valid = 1'b0;
    check_vec("s2_spur", 32'(spurious), 32'h1);
    check_vec("s2_ack", 32'(ack), 32'h00);
    check_vec("s2_insvc", 32'(in_service), 32'h08);
    step();
    check_vec("s2_spur_end", 32'(spurious), 32'h0);
    irq_lines = 8'h00;

    // EOI to a clear bit, then clear line 3.
    eoi = 1'b1; eoi_idx = 3'd6;
    step();
    check_vec("eoi_noeff", 32'(in_service), 32'h08);
    eoi_idx = 3'd3;
    step();
    eoi = 1'b0;
    check_vec("eoi_clr3", 32'(in_service), 32'h00);

    // EOI and re-acknowledge of line 0 in the same cycle.
    full_cycle(3'd0);
    check_vec("c_pre", 32'(in_service), 32'h01);
    irq_lines = 8'h01;
    req_if.req_valid = 1'b1; req_if.req_idx = 3'd0;
    eoi = 1'b1; eoi_idx = 3'd0;
    step();
    req_if.req_valid = 1'b0;
    eoi = 1'b0;
    check_vec("c_insvc", 32'(in_service), 32'h01);
    check_vec("c_ack", 32'(ack), 32'h01);
    check_vec("c_spur", 32'(spurious), 32'h0);
    step();
    step();
    irq_lines = 8'h00;
    step();
    eoi = 1'b1; eoi_idx = 3'd0;
    step();
    eoi = 1'b0;
    check_vec("c_clr", 32'(in_service), 32'h00);

    // Asynchronous reset one cycle into the pulse for line 7.
    irq_lines = 8'h80;
    req_if.req_valid = 1'b1; req_if.req_idx = 3'd7;
    step();
    req_if.req_valid = 1'b0;
    check_vec("r_ack_on", 32'(ack), 32'h80);
    #2;
    reset = 1'b0;
    #1;
    check_vec("r_ack_off", 32'(ack), 32'h00);
    check_vec("r_insvc", 32'(in_service), 32'h00);
    step();
    reset = 1'b1;
    #1;
    check_vec("r_ready", 32'(req_if.req_ready), 32'h1);
    step();
    check_vec("r_ack_idle", 32'(ack), 32'h00);
    irq_lines = 8'h00;
    step();

    // Line 2 never drops after its acknowledge.
    irq_lines = 8'h04;
    req_if.req_valid = 1'b1; req_if.req_idx = 3'd2;
    step();
    req_if.req_valid = 1'b0;
    step();
    step();
    check_vec("t_wait", 32'(req_if.req_ready), 32'h0);
`ifdef ACK_TIMEOUT_EN
    check_vec("t_err0", 32'(timeout_err), 32'h0);
    repeat (63) step();
    check_vec("t_still_wait", 32'(req_if.req_ready), 32'h0);
    check_vec("t_err_pre", 32'(timeout_err), 32'h0);
    check_vec("t_insvc_pre", 32'(in_service), 32'h04);
    step();
    check_vec("t_ready", 32'(req_if.req_ready), 32'h1);
    check_vec("t_err1", 32'(timeout_err), 32'h1);
    check_vec("t_insvc", 32'(in_service), 32'h00);
    irq_lines = 8'h00;
    repeat (3) step();
    check_vec("t_sticky", 32'(timeout_err), 32'h1);
`else
    repeat (100) step();
    check_vec("t_hang_ready", 32'(req_if.req_ready), 32'h0);
    check_vec("t_hang_insvc", 32'(in_service), 32'h04);
    irq_lines = 8'h00;
    step();
    check_vec("t_drop_ready", 32'(req_if.req_ready), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
